// File: rtl/booth_mul_arbiter_pkg.sv
// booth_mul_arbiter_pkg: shared state encoding and default sizing for the Booth multiplier arbiter and controller.
package booth_mul_arbiter_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_Q, BUSY, RESP} state_e;
    localparam int DEF_NREQ = 4;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/booth_mul_arbiter_rr_pick.sv
// booth_mul_arbiter_rr_pick: round-robin priority encoder, first set request at or after ptr, wrapping.
module booth_mul_arbiter_rr_pick
    import booth_mul_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);
    assign valid = |req;
    // Scan farthest offset first so the nearest request at or after ptr wins.
    always_comb begin
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            logic [IW-1:0] j;
            j = IW'((int'(ptr) + k) % NREQ);
            if (req[j]) idx = j;
        end
    end
endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sequencer sharing one Booth multiplier among NREQ clients.
module booth_mul_arbiter
    import booth_mul_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     mcand_in,
    input  logic [NREQ*WIDTH-1:0]     mplier_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]        rsp_prod,
    output logic                      rsp_err,
    output logic                      mul_start,
    output logic                      mul_clr,
    output logic [WIDTH-1:0]          mul_data,
    input  logic                      mul_done,
    input  logic [2*WIDTH-1:0]        mul_prod
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    state_e              state_q;
    logic [IW-1:0]       rr_q, id_q, pick_idx;
    logic                pick_v;
    logic [WIDTH-1:0]    b_q, pick_a, pick_b;
    logic [2*WIDTH-1:0]  prod_q;
    logic                err_q;
    logic [CW-1:0]       cnt_q;
    logic [NREQ-1:0]     gnt_q;
    logic                rsp_valid_q, rsp_err_q, mul_start_q, mul_clr_q;
    logic [IW-1:0]       rsp_id_q;
    logic [2*WIDTH-1:0]  rsp_prod_q;
    logic [WIDTH-1:0]    mul_data_q;

    booth_mul_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (req),
        .ptr  (rr_q),
        .valid(pick_v),
        .idx  (pick_idx)
    );

    assign pick_a = mcand_in[pick_idx*WIDTH +: WIDTH];
    assign pick_b = mplier_in[pick_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
            rsp_err_q   <= 1'b0;
            mul_start_q <= 1'b0;
            mul_clr_q   <= 1'b0;
            mul_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
            rsp_err_q   <= 1'b0;
            mul_start_q <= 1'b0;
            mul_clr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The response cycle itself never grants, keeping a gap before the next client.
                    if (pick_v && !rsp_valid_q) begin
                        id_q   <= pick_idx;
                        b_q    <= pick_b;
                        prod_q <= '0;
                        err_q  <= 1'b0;
                        gnt_q  <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        if (pick_a == '0 || pick_b == '0) begin
                            state_q <= RESP;
                        end else begin
                            state_q     <= LOAD_M;
                            mul_start_q <= 1'b1;
                            mul_data_q  <= pick_a;
                        end
                    end else begin
                        gnt_q <= '0;
                    end
                end
                LOAD_M: begin
                    mul_data_q <= b_q;
                    state_q    <= LOAD_Q;
                end
                LOAD_Q: begin
                    cnt_q   <= '0;
                    state_q <= BUSY;
                end
                BUSY: begin
                    // cnt_q==0 is the first BUSY cycle, where done may still be stale.
                    if (mul_done && cnt_q != '0) begin
                        prod_q  <= mul_prod;
                        state_q <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_q     <= 1'b1;
                        mul_clr_q <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    rsp_prod_q  <= prod_q;
                    rsp_err_q   <= err_q;
                    rr_q        <= (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    mul_data_q  <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_prod  = rsp_prod_q;
    assign rsp_err   = rsp_err_q;
    assign mul_start = mul_start_q;
    assign mul_clr   = mul_clr_q;
    assign mul_data  = mul_data_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: directed scoreboard bench with a behavioural multiplier model.
module tb_booth_mul_arbiter;
    localparam int LAT = 3;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] prod;
        logic        err;
    } exp_t;

    logic        clk, rst;
    logic [3:0]  req;
    logic [63:0] mcand_in, mplier_in;
    logic [3:0]  gnt;
    logic        rsp_valid, rsp_err, mul_start, mul_clr, mul_done;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_prod, mul_prod;
    logic [15:0] mul_data;

    exp_t sb[$];
    exp_t e;
    int vectors = 0;
    int miscompares = 0;
    int starts = 0;
    int clrs = 0;
    logic stall;

    booth_mul_arbiter #(.NREQ(4), .WIDTH(16), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .mcand_in(mcand_in), .mplier_in(mplier_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
        .rsp_err(rsp_err), .mul_start(mul_start), .mul_clr(mul_clr), .mul_data(mul_data),
        .mul_done(mul_done), .mul_prod(mul_prod)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] smul(input logic signed [15:0] a, input logic signed [15:0] b);
        logic signed [31:0] r;
        r = a * b;
        return r;
    endfunction

    // Multiplier core stand-in: start+mcand, then mplier, then done after LAT cycles.
    logic [15:0] ma, mq;
    int ph, mcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_done <= 0; mul_prod <= 0; ph <= 0; mcnt <= 0;
        end else if (mul_clr) begin
            mul_done <= 0; ph <= 0;
        end else if (mul_start) begin
            ma <= mul_data; ph <= 1; mul_done <= 0;
        end else if (ph == 1) begin
            mq <= mul_data; ph <= 2; mcnt <= LAT;
        end else if (ph == 2) begin
            if (mcnt != 0) mcnt <= mcnt - 1;
            else if (!stall) begin
                mul_done <= 1; mul_prod <= smul(ma, mq); ph <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input logic [1:0] id, input logic [31:0] prod, input logic err);
        exp_t x;
        x.id = id; x.prod = prod; x.err = err;
        sb.push_back(x);
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        mcand_in[i*16 +: 16] = a;
        mplier_in[i*16 +: 16] = b;
    endtask

    task automatic drain(input int max);
        for (int c = 0; c < max && sb.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain", 64'(sb.size()), 0);
    endtask

    always @(negedge clk) begin
        chk("gnt_onehot", 64'($countones(gnt) <= 1), 1);
        if (mul_start) starts++;
        if (mul_clr) clrs++;
        if (rsp_valid) begin
            if (sb.size() == 0) chk("unexpected_rsp", 64'(sb.size()), 1);
            else begin
                e = sb.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_prod", rsp_prod, e.prod);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_gnt", gnt, 4'b0001 << e.id);
            end
        end
    end

    initial begin
        int s0, c0, cyc;
        rst = 1; req = 0; mcand_in = 0; mplier_in = 0; stall = 0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_mul_clr", mul_clr, 0);
        chk("rst_mul_data", mul_data, 0);
        chk("rst_rsp_prod", rsp_prod, 0);
        rst = 0;

        @(negedge clk);
        set_op(0, 16'd35, 16'd30); req = 4'b0001; expect_rsp(0, 32'd1050, 0);
        @(posedge clk); #1;
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_start", mul_start, 1);
        chk("t1_mcand", mul_data, 16'd35);
        @(posedge clk); #1;
        chk("t1_start_off", mul_start, 0);
        chk("t1_mplier", mul_data, 16'd30);
        drain(100); req = 0;

        @(negedge clk);
        s0 = starts;
        set_op(1, 16'd0, 16'd1234); req = 4'b0010; expect_rsp(1, 32'd0, 0);
        @(posedge clk); #1;
        chk("zero_gnt", gnt, 4'b0010);
        chk("zero_early", rsp_valid, 0);
        @(posedge clk); #1;
        chk("zero_valid", rsp_valid, 1);
        drain(20); req = 0;
        chk("zero_no_start", 64'(starts), 64'(s0));

        @(negedge clk);
        set_op(2, 16'hFFFD, 16'd7); req = 4'b0100; expect_rsp(2, 32'hFFFFFFEB, 0);
        drain(100); req = 0;

        @(negedge clk);
        set_op(3, 16'h8000, 16'h8000); req = 4'b1000; expect_rsp(3, 32'h40000000, 0);
        drain(100); req = 0;

        @(negedge clk);
        set_op(0, 16'd100, -16'sd200);
        set_op(1, 16'hFFFF, 16'hFFFF);
        set_op(2, 16'h7FFF, 16'h7FFF);
        set_op(3, 16'd7, -16'sd9);
        req = 4'b1111;
        expect_rsp(0, 32'hFFFFB1E0, 0);
        expect_rsp(1, 32'd1, 0);
        expect_rsp(2, 32'h3FFF0001, 0);
        expect_rsp(3, 32'hFFFFFFC1, 0);
        expect_rsp(0, 32'hFFFFB1E0, 0);
        drain(400); req = 0;

        @(negedge clk);
        stall = 1; c0 = clrs;
        set_op(1, 16'd5, 16'd5); req = 4'b0010; expect_rsp(1, 32'd0, 1);
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (mul_clr) begin cyc = c; break; end
        end
        chk("timeout_clr_cycle", 64'(cyc), 67);
        drain(20); req = 0; stall = 0;
        chk("timeout_clr_pulses", 64'(clrs), 64'(c0 + 1));

        @(negedge clk);
        set_op(2, 16'd11, -16'sd13); req = 4'b0100; expect_rsp(2, 32'hFFFFFF71, 0);
        drain(100); req = 0;

        @(negedge clk);
        stall = 1;
        set_op(0, 16'd9, 16'd9); req = 4'b0001;
        repeat (6) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_mul_data", mul_data, 0);
        chk("arst_mul_start", mul_start, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        @(negedge clk); req = 0;
        repeat (2) @(negedge clk);
        rst = 0; stall = 0;

        @(negedge clk);
        set_op(3, 16'd5, 16'd6); req = 4'b1000; expect_rsp(3, 32'd30, 0);
        drain(100); req = 0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
